// File: rtl/pp_accumulator_pkg.sv
// Shared multiplier definitions: mantissa/partial-product geometry and the
// accumulator FSM encoding.
package pp_accumulator_pkg;

    localparam int MANT_W = 23;
    localparam int PP_CNT = (MANT_W + 3) / 2;
    localparam int PP_W   = 2 * MANT_W + 3;
    localparam int PROD_W = 2 * MANT_W + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REDUCE  = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Two partial products are folded into the carry-save pair per row.
    function automatic int reduce_rows(input int n_pp);
        return (n_pp + 1) / 2;
    endfunction

endpackage

// File: rtl/pp_accumulator_csa.sv
// 4:2 carry-save row built from two cascaded 3:2 levels; all arithmetic
// is modulo 2^W, so carries shifted past the MSB are dropped.
module csa_4to2
    import pp_accumulator_pkg::*;
#(
    parameter int W = PP_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    logic [W-1:0] s1;
    logic [W-1:0] c1;

    assign s1 = a_i ^ b_i ^ c_i;
    assign c1 = {(a_i[W-2:0] & b_i[W-2:0]) | (a_i[W-2:0] & c_i[W-2:0]) |
                 (b_i[W-2:0] & c_i[W-2:0]), 1'b0};

    assign sum_o   = s1 ^ c1 ^ d_i;
    assign carry_o = {(s1[W-2:0] & c1[W-2:0]) | (s1[W-2:0] & d_i[W-2:0]) |
                      (c1[W-2:0] & d_i[W-2:0]), 1'b0};

endmodule

// File: rtl/pp_accumulator.sv
// Iterative Booth partial-product accumulator: captures 13 partial products,
// folds two per cycle into a carry-save pair, then resolves to the product.
module pp_accumulator
    import pp_accumulator_pkg::*;
#(
    parameter int PARM_MANT = MANT_W,
    parameter int PARM_PP   = (PARM_MANT + 3) / 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [2*PARM_MANT+2:0]   pp_00_i,
    input  logic [2*PARM_MANT+2:0]   pp_01_i,
    input  logic [2*PARM_MANT+2:0]   pp_02_i,
    input  logic [2*PARM_MANT+2:0]   pp_03_i,
    input  logic [2*PARM_MANT+2:0]   pp_04_i,
    input  logic [2*PARM_MANT+2:0]   pp_05_i,
    input  logic [2*PARM_MANT+2:0]   pp_06_i,
    input  logic [2*PARM_MANT+2:0]   pp_07_i,
    input  logic [2*PARM_MANT+2:0]   pp_08_i,
    input  logic [2*PARM_MANT+2:0]   pp_09_i,
    input  logic [2*PARM_MANT+2:0]   pp_10_i,
    input  logic [2*PARM_MANT+2:0]   pp_11_i,
    input  logic [2*PARM_MANT+1:0]   pp_12_i,
    input  logic                     pp_valid_i,
    output logic                     pp_ready_o,
    output logic [2*PARM_MANT+1:0]   prod_o,
    output logic                     prod_valid_o,
    input  logic                     prod_ready_i
);

    localparam int PPW    = 2 * PARM_MANT + 3;
    localparam int PRODW  = 2 * PARM_MANT + 2;
    localparam int ROWS   = reduce_rows(PARM_PP);
    localparam int CNT_W  = $clog2(ROWS);
    localparam int LAST_K = ROWS - 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PPW-1:0]     sum_q, sum_d;
    logic [PPW-1:0]     carry_q, carry_d;
    logic [PRODW-1:0]   prod_q, prod_d;
    logic [PPW-1:0]     bank_q [PARM_PP];
    logic [PPW-1:0]     pp_in  [PARM_PP];
    logic [PPW-1:0]     op_a, op_b;
    logic [PPW-1:0]     csa_sum, csa_carry;
    logic               accept;

    assign pp_in[0]  = pp_00_i;
    assign pp_in[1]  = pp_01_i;
    assign pp_in[2]  = pp_02_i;
    assign pp_in[3]  = pp_03_i;
    assign pp_in[4]  = pp_04_i;
    assign pp_in[5]  = pp_05_i;
    assign pp_in[6]  = pp_06_i;
    assign pp_in[7]  = pp_07_i;
    assign pp_in[8]  = pp_08_i;
    assign pp_in[9]  = pp_09_i;
    assign pp_in[10] = pp_10_i;
    assign pp_in[11] = pp_11_i;
    assign pp_in[12] = {1'b0, pp_12_i};

    assign pp_ready_o   = (state_q == IDLE);
    assign prod_valid_o = (state_q == DONE);
    assign prod_o       = prod_q;
    assign accept       = pp_valid_i && (state_q == IDLE);

    // Row k reads pp[2k] and pp[2k+1]; the odd slot past the bank reads zero.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < PARM_PP; i++) begin
            if (i == 2 * int'(cnt_q))     op_a = bank_q[i];
            if (i == 2 * int'(cnt_q) + 1) op_b = bank_q[i];
        end
    end

    csa_4to2 #(.W(PPW)) u_csa (
        .a_i     (sum_q),
        .b_i     (carry_q),
        .c_i     (op_a),
        .d_i     (op_b),
        .sum_o   (csa_sum),
        .carry_o (csa_carry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (pp_valid_i) begin
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                sum_d   = csa_sum;
                carry_d = csa_carry;
                if (cnt_q == CNT_W'(LAST_K)) state_d = RESOLVE;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            RESOLVE: begin
                // Bit 48 of the sum is the discarded carry-out.
                prod_d  = sum_q[PRODW-1:0] + carry_q[PRODW-1:0];
                state_d = DONE;
            end
            DONE: begin
                if (prod_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            prod_q  <= '0;
            for (int i = 0; i < PARM_PP; i++) bank_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            prod_q  <= prod_d;
            if (accept) begin
                for (int i = 0; i < PARM_PP; i++) bank_q[i] <= pp_in[i];
            end
        end
    end

endmodule

// File: doc/pp_accumulator.md
PP_ACCUMULATOR -- requirements
Module: pp_accumulator

Interface
REQ-001 SHALL have parameter PARM_MANT, default 23, meaning the stored mantissa width (multiplicand is PARM_MANT+1 bits including the hidden bit).
REQ-002 SHALL have parameter PARM_PP, default 13, meaning the partial-product count, fixed as (PARM_MANT+3)/2.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, the reset; it is asynchronous and active-high.
REQ-005 SHALL have ports pp_00_i..pp_11_i, input, 2*PARM_MANT+3 (49) each, Booth partial products 0-11.
REQ-006 SHALL have port pp_12_i, input, 2*PARM_MANT+2 (48), the last partial product.
REQ-007 SHALL have port pp_valid_i, input, 1, which is high when the upstream partial-product set is valid.
REQ-008 SHALL have port pp_ready_o, output, 1, which is high when the block accepts a new set.
REQ-009 SHALL have port prod_o, output, 2*PARM_MANT+2 (48), the unsigned mantissa product.
REQ-010 SHALL have port prod_valid_o, output, 1, which is high when prod_o is valid.
REQ-011 SHALL have port prod_ready_i, input, 1, which is high when downstream accepts prod_o.

Function
REQ-012 SHALL use the FSM states IDLE, REDUCE, RESOLVE and DONE.
REQ-013 SHALL drive pp_ready_o = (state==IDLE) and prod_valid_o = (state==DONE); both are registered-state decodes.
REQ-014 SHALL, on an accept edge (pp_valid_i & pp_ready_o), capture all 13 inputs into an internal bank (pp_12 zero-extended to 49 bits), clear the sum/carry registers and the count, and go to REDUCE.
REQ-015 SHALL, on each REDUCE cycle with count k=0..6, compress sum, carry, pp[2k] and pp[2k+1] through a 4:2 carry-save row into new sum/carry; pp[13] is treated as zero.
REQ-016 SHALL, at k=6, go to RESOLVE.
REQ-017 SHALL, in RESOLVE, do one carry-propagate add sum+carry, register the low 48 bits into prod_o and go to DONE.
REQ-018 SHALL hold prod_o and prod_valid_o stable while in DONE with prod_ready_i low.
REQ-019 SHALL go from DONE to IDLE on the edge where prod_ready_i is high.
REQ-020 SHALL have a latency of exactly 8 edges from the accept edge to the edge that sets prod_valid_o.
REQ-021 SHALL, with prod_ready_i held high, accept at most one set every 10 cycles.
REQ-022 SHALL keep all internal arithmetic modulo 2^49; prod_o SHALL equal (sum of the 13 inputs) mod 2^48, with the carry-out discarded and no overflow flag.
REQ-023 SHALL, when driven by a Booth radix-4 encoder of mantissas A and B, produce prod_o = A*B exactly.
REQ-024 SHALL ignore inputs and pp_valid_i outside IDLE; upstream holds the data until accepted.
REQ-025 SHALL NOT change prod_o in any state other than RESOLVE.

Reset
REQ-026 SHALL, while rst_i is high, immediately force state=IDLE, count=0, and sum, carry, the PP bank and prod_o to 0.
REQ-027 SHALL therefore reset pp_ready_o to 1 and prod_valid_o to 0.
REQ-028 SHALL, on reset during REDUCE, RESOLVE or DONE, discard the in-flight operation with no output produced.
REQ-029 SHALL accept the first set no earlier than the first edge after rst_i deasserts.

Structure
REQ-030 SHALL place PARM_MANT, PARM_PP, the PP and product widths, and the state encoding (2-bit IDLE=0, REDUCE=1, RESOLVE=2, DONE=3) in a shared multiplier package.
REQ-031 SHALL implement the 4:2 carry-save row as sub-module csa_4to2, 49 bits wide and purely combinational, built from two 3:2 levels.

Verification
REQ-032 SHALL verify the Booth-encoded set for A=B=24'h800000 -> prod_o=48'h400000000000, with prod_valid_o high exactly 8 edges after accept.
REQ-033 SHALL verify the Booth-encoded set for A=B=24'hFFFFFF -> prod_o=48'hFFFFFE000001.
REQ-034 SHALL verify raw stimulus pp_00_i=1, pp_12_i=1, all other inputs 0 -> prod_o=48'h000000000002.
REQ-035 SHALL verify wrap-around: pp_00_i..pp_11_i all 49'h1FFFFFFFFFFFF and pp_12_i=48'hFFFFFFFFFFFF -> prod_o=48'hFFFFFFFFFFF3.
REQ-036 SHALL verify backpressure: prod_ready_i held low 5 cycles in DONE -> prod_o constant and pp_ready_o=0; after release, pp_ready_o=1 on the next cycle.
REQ-037 SHALL verify reset mid-operation: rst_i pulsed at REDUCE count 3 -> prod_valid_o stays 0, pp_ready_o=1 immediately, and the next set is processed with the normal 8-edge latency.
